// File: rtl/game_pkg.sv
// Shared screen-controller types and defaults.
package game_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    START = 2'd1,
    GAME  = 2'd2,
    OVER  = 2'd3
  } screen_e;

  localparam int unsigned GAMEOVER_FRAMES_DEF = 180;
  localparam int unsigned START_FRAMES_DEF    = 1;

endpackage

// File: rtl/edge_detect.sv
// Registered single-bit rising-edge detector.
module edge_detect #(
  // History value after reset; 1 suppresses an "edge" from a level already high at reset release.
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= INIT;
      pulse <= 1'b0;
    end else begin
      d_q   <= d;
      pulse <= d & ~d_q;
    end
  end

endmodule

// File: rtl/screen_ctrl.sv
// Frame-synchronous screen sequencer: MENU -> START -> GAME -> OVER -> MENU.
module screen_ctrl
  import game_pkg::*;
#(
  parameter int unsigned GAMEOVER_FRAMES = GAMEOVER_FRAMES_DEF,
  parameter int unsigned START_FRAMES    = START_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start_btn,
  input  logic       game_end,
  output logic [1:0] screen_sel,
  output logic       menu_en,
  output logic       game_en,
  output logic       game_rst,
  output logic       frame_tick
);

  localparam logic [7:0] StartLast = 8'(START_FRAMES - 1);
  localparam logic [7:0] OverLast  = 8'(GAMEOVER_FRAMES - 1);

  screen_e    state_q, state_d;
  logic       start_pulse;
  logic       start_req_q, start_req_d;
  logic       end_req_q, end_req_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       leave;

  edge_detect #(.INIT(1'b0)) u_vsync_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (vsync_in),
    .pulse (frame_tick)
  );

  // A button held through reset must not count as a fresh press.
  edge_detect #(.INIT(1'b1)) u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (start_btn),
    .pulse (start_pulse)
  );

  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        MENU:    if (start_req_q) state_d = START;
        START:   if (frame_cnt_q >= StartLast) state_d = GAME;
        GAME:    if (end_req_q) state_d = OVER;
        OVER:    if (frame_cnt_q >= OverLast) state_d = MENU;
        default: state_d = MENU;
      endcase
    end
  end

  always_comb begin
    leave       = (state_d != state_q);
    frame_cnt_d = frame_cnt_q;
    if (leave) begin
      frame_cnt_d = 8'd0;
    end else if (frame_tick && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
    // Requests only accumulate in their own state and drop on exit.
    start_req_d = ((state_q == MENU) && !leave) ? (start_req_q | start_pulse) : 1'b0;
    end_req_d   = ((state_q == GAME) && !leave) ? (end_req_q | game_end) : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MENU;
      start_req_q <= 1'b0;
      end_req_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      screen_sel  <= 2'd0;
      menu_en     <= 1'b1;
      game_en     <= 1'b0;
      game_rst    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_req_q <= start_req_d;
      end_req_q   <= end_req_d;
      frame_cnt_q <= frame_cnt_d;
      screen_sel  <= state_d;
      menu_en     <= (state_d == MENU);
      game_en     <= (state_d != MENU);
      game_rst    <= (state_q == MENU) && (state_d == START);
    end
  end

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed bench for screen_ctrl with default parameters.
module tb_screen_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       start_btn;
  logic       game_end;
  logic [1:0] screen_sel;
  logic       menu_en;
  logic       game_en;
  logic       game_rst;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int rst_pulses = 0;
  logic last_tick;

  screen_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .start_btn  (start_btn),
    .game_end   (game_end),
    .screen_sel (screen_sel),
    .menu_en    (menu_en),
    .game_en    (game_en),
    .game_rst   (game_rst),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (game_rst === 1'b1) rst_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: vsync high for two cycles; returns just after the FSM update edge.
  task automatic frame(input logic press);
    @(negedge clk);
    vsync_in = 1'b1;
    if (press) start_btn = 1'b1;
    @(negedge clk);
    last_tick = frame_tick;
    @(negedge clk);
    vsync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_end();
    @(negedge clk);
    game_end = 1'b1;
    @(negedge clk);
    game_end = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vsync_in = 1'b0; start_btn = 1'b0; game_end = 1'b0;
    #1;
    check("rst_screen_sel", screen_sel, 0);
    check("rst_menu_en", menu_en, 1);
    check("rst_game_en", game_en, 0);
    check("rst_game_rst", game_rst, 0);
    check("rst_frame_tick", frame_tick, 0);
    idle(2);
    rst = 1'b0;

    // Idle frames stay in MENU
    for (int i = 0; i < 3; i++) begin
      frame(1'b0);
      check("idle_tick_seen", last_tick, 1);
      check("idle_tick_single", frame_tick, 0);
      check("idle_screen_sel", screen_sel, 0);
      check("idle_menu_en", menu_en, 1);
    end
    check("idle_no_game_rst", rst_pulses, 0);

    // Mid-frame press enters START on the next tick with one game_rst pulse
    idle(1);
    start_btn = 1'b1;
    idle(2);
    frame(1'b0);
    check("start_screen_sel", screen_sel, 1);
    check("start_game_rst", game_rst, 1);
    check("start_game_en", game_en, 1);
    check("start_menu_en", menu_en, 0);
    idle(1);
    check("start_game_rst_low", game_rst, 0);
    check("start_rst_count", rst_pulses, 1);
    frame(1'b0);
    check("game_screen_sel", screen_sel, 2);
    frame(1'b0);
    check("game_hold", screen_sel, 2);

    // Start edge and game_end together in GAME: only the end request counts
    start_btn = 1'b0;
    idle(2);
    @(negedge clk);
    start_btn = 1'b1;
    game_end = 1'b1;
    @(negedge clk);
    game_end = 1'b0;
    idle(1);
    frame(1'b0);
    check("over_screen_sel", screen_sel, 3);
    check("over_game_en", game_en, 1);

    // Press during OVER is discarded
    start_btn = 1'b0;
    idle(2);
    start_btn = 1'b1;
    for (int i = 0; i < 179; i++) frame(1'b0);
    check("over_179", screen_sel, 3);
    frame(1'b0);
    check("over_180_menu", screen_sel, 0);
    check("over_180_menu_en", menu_en, 1);
    frame(1'b0);
    frame(1'b0);
    check("over_press_dropped", screen_sel, 0);
    check("over_rst_count", rst_pulses, 1);

    // Start edge coincident with frame_tick: transition one frame later
    start_btn = 1'b0;
    idle(2);
    frame(1'b1);
    check("coinc_still_menu", screen_sel, 0);
    frame(1'b0);
    check("coinc_start", screen_sel, 1);
    check("coinc_game_rst", game_rst, 1);
    idle(1);
    check("coinc_rst_count", rst_pulses, 2);
    frame(1'b0);
    check("coinc_game", screen_sel, 2);

    // Reset in GAME with end_req pending
    pulse_end();
    idle(1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_screen_sel", screen_sel, 0);
    check("midrst_menu_en", menu_en, 1);
    check("midrst_game_en", game_en, 0);
    check("midrst_game_rst", game_rst, 0);
    @(negedge clk);
    rst = 1'b0;
    frame(1'b0);
    frame(1'b0);
    check("midrst_held_btn_menu", screen_sel, 0);
    check("midrst_rst_count", rst_pulses, 2);

    // game_end in MENU ignored; stale end_req must not end the new round
    pulse_end();
    start_btn = 1'b0;
    idle(2);
    start_btn = 1'b1;
    idle(2);
    frame(1'b0);
    check("round2_start", screen_sel, 1);
    idle(1);
    check("round2_rst_count", rst_pulses, 3);
    frame(1'b0);
    check("round2_game", screen_sel, 2);
    frame(1'b0);
    check("round2_no_stale_end", screen_sel, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_ctrl.md
SCREEN_CTRL -- requirements
Module: screen_ctrl

Interface
REQ-001 Parameter GAMEOVER_FRAMES, default 180, number of frames the game-over screen is held (range 1..255).
REQ-002 Parameter START_FRAMES, default 1, number of frames spent in START before GAME (range 1..255).
REQ-003 clk  input  1  pixel clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 vsync_in  input  1  vertical sync from the VGA timing chain; a frame boundary is its rising edge.
REQ-006 start_btn  input  1  synchronised start button, level.
REQ-007 game_end  input  1  single-cycle pulse from game logic (player lost or won).
REQ-008 screen_sel  output  2  selected screen layer: 0 = MENU, 1 = START, 2 = GAME, 3 = OVER.
REQ-009 menu_en  output  1  high while the menu drawing chain drives the output mux.
REQ-010 game_en  output  1  high while the game drawing chain drives the output mux.
REQ-011 game_rst  output  1  single-cycle pulse that clears game state before a new round.
REQ-012 frame_tick  output  1  single-cycle pulse, one cycle after each detected vsync_in rising edge.

Function
REQ-013 The block SHALL register vsync_in once and detect a rising edge as current high and previous low; frame_tick SHALL be that registered detection.
REQ-014 The block SHALL detect the rising edge of start_btn and latch it into start_req; start_req SHALL be cleared on leaving MENU.
REQ-015 game_end pulses SHALL be latched into end_req while in GAME; end_req SHALL be cleared on leaving GAME, and pulses in other states SHALL be ignored.
REQ-016 The FSM states SHALL be MENU, START, GAME and OVER, and the FSM SHALL change state only in the cycle of frame_tick.
REQ-017 MENU -> START when frame_tick and start_req are both high; game_rst SHALL pulse in the same cycle as the state register update.
REQ-018 START -> GAME after START_FRAMES frame_ticks counted in START.
REQ-019 GAME -> OVER when frame_tick and end_req are both high.
REQ-020 OVER -> MENU after GAMEOVER_FRAMES frame_ticks counted in OVER; start_btn edges in OVER SHALL be discarded (start_req not set).
REQ-021 An 8-bit frame counter SHALL clear on every state change and increment on frame_tick otherwise; it SHALL saturate at 255.
REQ-022 If start_btn rises and game_end pulses in the same cycle, each SHALL be handled only by its own state rule (REQ-014, REQ-015).
REQ-023 If a start edge arrives in the same cycle as frame_tick in MENU, the transition SHALL occur on the next frame_tick, not the current one.
REQ-024 screen_sel, menu_en and game_en SHALL be registered decodes of the state: menu_en = (MENU); game_en = (START or GAME or OVER). Their latency from the state register SHALL be 0 cycles, and they SHALL update in the same edge as the state.
REQ-025 All outputs SHALL be glitch-free registered signals.

Reset
REQ-026 On rst, the FSM SHALL go to MENU asynchronously.
REQ-027 On rst, the following SHALL clear: start_req, end_req, the frame counter, and the vsync history register.
REQ-028 On rst, the outputs SHALL take these values: screen_sel=0, menu_en=1, game_en=0, game_rst=0, frame_tick=0.
REQ-029 rst asserted mid-round SHALL abandon the round without issuing game_rst; a new round SHALL require a fresh start edge.

Structure
REQ-030 The state enum (MENU/START/GAME/OVER, 2-bit) SHALL live in a shared package, game_pkg, together with a constant for the default GAMEOVER_FRAMES.
REQ-031 Edge detection SHALL be one sub-module, edge_detect (1-bit, rising, registered), instantiated for vsync_in and start_btn.

Verification
REQ-032 Reset release, no inputs, 3 frames -> screen_sel=0, menu_en=1, game_rst never high.
REQ-033 start_btn rises mid-frame in MENU -> at the next frame_tick game_rst pulses for 1 cycle and screen_sel=1; one frame later screen_sel=2.
REQ-034 game_end pulses in GAME -> screen_sel=3 at the next frame_tick; screen_sel=0 after exactly 180 further frame_ticks.
REQ-035 start_btn pressed during OVER -> the FSM returns to MENU and stays there (no START) until a new start edge.
REQ-036 rst asserted in GAME with end_req pending -> immediate screen_sel=0; no game_rst; end_req is cleared.
REQ-037 start edge coincident with frame_tick in MENU -> the transition is delayed by exactly one frame.
